log_mac_pipe: RTL
=================

Name: log_mac_pipe

Overview:
Pipelined, parametrised successor to the team's combinational log-domain multiplier.
- Multiplies two signed fixed-point operands using Mitchell log2/antilog approximation.
- Has a valid/ready stream interface with back-pressure.
- Runtime mode either emits every product or accumulates a group of products into one saturated dot-product term.
- Sits in the FLAF weight-update / filter-output datapath, replacing per-tap combinational log multipliers.

Parameters:
- WIDTH, 16, operand and product word width (signed).
- QP1, 12, fraction bits of in1.
- QP2, 12, fraction bits of in2.
- QPO, 12, fraction bits of the product and of the accumulator.
- FRAC, 12, log-domain fraction bits (mantissa precision).
- ACC_WIDTH, 24, accumulator/output width (signed), ACC_WIDTH >= WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in1  in  WIDTH  signed operand, Q(WIDTH-QP1).QP1.
- in2  in  WIDTH  signed operand, Q(WIDTH-QP2).QP2.
- mac_mode  in  1  0 = product per beat; 1 = accumulate; travels with the beat.
- in_last  in  1  last beat of an accumulation group; ignored when mac_mode=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_WIDTH  signed result, QPO fraction bits.

Behaviour:
- Reset (async assert, sync deassert outside block):
  - All stage valids, out_valid, out_data = 0.
  - Accumulator = 0; group-open flag cleared.
  - Reset mid-group discards the partial sum.
- Stall / handshake:
  - Global enable en = !out_valid | out_ready; in_ready = en.
  - A beat transfers when in_valid & in_ready; a result transfers when out_valid & out_ready.
  - While en=0 every stage holds. out_data is stable while out_valid & !out_ready.
- Stages:
  - S1: sign = MSB, |x| held in WIDTH bits unsigned (so -2^(WIDTH-1) is exact). k = leading-one index. f = bits below the leading one, left-aligned to FRAC bits (zero-pad or truncate). zero flag set if either operand is 0.
  - S2: L = (k1-QP1) + (k2-QP2) + f1 + f2, signed fixed point with FRAC fraction bits. A fraction carry increments the integer part I; F = fraction of L. sign = s1^s2.
  - S3: mag = (2^FRAC + F) shifted by (I + QPO - FRAC); left if >= 0, right with truncation if < 0. mag saturates to 2^(WIDTH-1)-1. zero flag forces mag = 0. Apply sign (negation of the saturated magnitude, so range is symmetric).
  - S4 (output register):
    - mac_mode=0: out_data = sign-extended product; out_valid = 1.
    - mac_mode=1: first beat of a group loads acc = product; later beats do acc += product, saturating to ±(2^(ACC_WIDTH-1)-1). On in_last, out_data = updated acc, out_valid = 1, group closes.
    - Non-last MAC beats produce no output.
- Latency: beat accepted at edge n → out_valid from edge n+4, absent stalls. Throughput is 1 beat/clock.
- A mode-0 beat arriving inside an open group passes through and leaves the accumulator untouched.
- A single-beat group (in_last on first beat) outputs that product.
- Stall on the same edge as in_last: nothing advances until en=1.

Optional Feature:
- Macro LOGMAC_SAT_FLAG_EN.
- Defined: adds output port sat_flag (1 bit, reset 0). It is a sticky high set on any product saturation (S3) or accumulator saturation (S4). It is cleared only by rst_n.
- Undefined: no port, no logic; saturation is still performed silently.

Test Plan:
- mode0, in1=4096, in2=4096 (1.0×1.0) → out_data=4096 exactly 4 cycles after acceptance.
- mode0, 6144×6144 (1.5×1.5) → 8192 (Mitchell result); 8192×-12288 (2.0×-3.0) → -24576.
- mode0, 16384×16384 (4.0×4.0) → 32767; 16384×-16384 → -32767; -32768×0 → 0. With LOGMAC_SAT_FLAG_EN, sat_flag goes 1 after the first and stays 1.
- mode1 group {4096×4096, 8192×-12288, 4096×4096 with in_last} → single output -16384. No out_valid for the first two beats.
- Back-to-back mode0 stream with out_ready held low 3 cycles mid-stream → no beat lost or duplicated, out_data stable while stalled, in_ready=0 during stall.
- rst_n pulsed low after two MAC beats of an open group; then group {4096×4096, last} → output 4096 (no stale partial sum).

Source files
------------

// File: rtl/log_mac_pipe.sv
// log_mac_pipe: pipelined Mitchell log-domain signed multiplier with optional saturating MAC.
//
// Five register stages: input capture, S1 log encode, S2 log add, S3 antilog,
// S4 output/accumulate. A beat accepted on edge n shows out_valid after edge n+4.
// Every stage advances only on en = !out_valid | out_ready, which also drives in_ready.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (== en)
//   in1, in2   signed operands, QP1 / QP2 fraction bits
//   mac_mode   0 = one product per beat, 1 = accumulate a group
//   in_last    closes an accumulation group (mac_mode=1 only)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   signed result, QPO fraction bits, ACC_WIDTH bits
//   sat_flag   sticky saturation indicator, present only with LOGMAC_SAT_FLAG_EN
//
// Optional feature macro: LOGMAC_SAT_FLAG_EN
module log_mac_pipe #(
  parameter int WIDTH     = 16,
  parameter int QP1       = 12,
  parameter int QP2       = 12,
  parameter int QPO       = 12,
  parameter int FRAC      = 12,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 mac_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef LOGMAC_SAT_FLAG_EN
  output logic                 sat_flag,
`endif
  output logic [ACC_WIDTH-1:0] out_data
);
  localparam int KW = $clog2(WIDTH);
  localparam int IW = KW + 8;
  localparam int TW = FRAC + WIDTH + 1;
  localparam logic signed [IW-1:0] C_QIN  = IW'(QP1 + QP2);
  localparam logic signed [IW-1:0] C_QPO  = IW'(QPO);
  localparam logic signed [IW-1:0] C_FRAC = IW'(FRAC);
  localparam logic signed [IW-1:0] C_LIM  = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_PMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] C_AMAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] C_AMIN = -C_AMAX;

  function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] x);
    lead_one = '0;
    for (int i = 0; i < WIDTH; i++)
      if (x[i]) lead_one = KW'(i);
  endfunction

  // Bits below the leading one, left-aligned into FRAC bits (zero-padded or truncated).
  function automatic logic [FRAC-1:0] mant_frac(input logic [WIDTH-1:0] x, input logic [KW-1:0] k);
    logic [WIDTH-1:0]        n;
    logic [WIDTH+FRAC-2:0]   t;
    n = x << (KW'(WIDTH - 1) - k);
    t = {n[WIDTH-2:0], {FRAC{1'b0}}};
    mant_frac = t[WIDTH+FRAC-2 -: FRAC];
  endfunction

  logic w_en;
  assign w_en     = !out_valid | out_ready;
  assign in_ready = w_en;

  // Stage 0: raw operand capture.
  logic             r_v0, r_m0, r_l0;
  logic [WIDTH-1:0] r_a0, r_b0;

  // S1: sign, magnitude, leading-one index, fraction.
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [KW-1:0]    w_ka, w_kb;
  assign w_abs_a = r_a0[WIDTH-1] ? -r_a0 : r_a0;
  assign w_abs_b = r_b0[WIDTH-1] ? -r_b0 : r_b0;
  assign w_ka    = lead_one(w_abs_a);
  assign w_kb    = lead_one(w_abs_b);

  logic            r_v1, r_m1, r_l1, r_s1, r_z1;
  logic [KW-1:0]   r_ka1, r_kb1;
  logic [FRAC-1:0] r_fa1, r_fb1;

  // S2: log-domain add; a fraction carry bumps the integer part.
  logic [FRAC:0]          w_fsum;
  logic signed [IW-1:0]   w_int;
  assign w_fsum = {1'b0, r_fa1} + {1'b0, r_fb1};
  assign w_int  = IW'(r_ka1) + IW'(r_kb1) - C_QIN + IW'(w_fsum[FRAC]);

  logic                 r_v2, r_m2, r_l2, r_s2, r_z2;
  logic signed [IW-1:0] r_i2;
  logic [FRAC-1:0]      r_f2;

  // S3: antilog. w_e is the bit position the implicit one lands on after shifting.
  logic signed [IW-1:0] w_e, w_sh, w_nsh;
  logic                 w_psat;
  logic [FRAC:0]        w_mant;
  logic [TW-1:0]        w_t;
  logic [WIDTH-1:0]     w_mag, w_prod;
  assign w_e    = r_i2 + C_QPO;
  assign w_sh   = w_e - C_FRAC;
  assign w_nsh  = -w_sh;
  assign w_psat = (w_e >= C_LIM) & !r_z2;
  assign w_mant = {1'b1, r_f2};
  assign w_t    = w_sh[IW-1] ? (TW'(w_mant) >> w_nsh) : (TW'(w_mant) << w_sh);
  assign w_mag  = r_z2 ? '0 : w_psat ? C_PMAX : w_t[WIDTH-1:0];
  assign w_prod = r_s2 ? -w_mag : w_mag;

  logic             r_v3, r_m3, r_l3;
  logic [WIDTH-1:0] r_p3;

  // S4: sign-extend product and saturating accumulate.
  logic                        r_open;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_pext, w_base, w_accn;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic                        w_hi, w_lo;
  assign w_pext = ACC_WIDTH'($signed(r_p3));
  assign w_base = r_open ? r_acc : '0;
  assign w_sum  = {w_base[ACC_WIDTH-1], w_base} + {w_pext[ACC_WIDTH-1], w_pext};
  assign w_hi   = w_sum > C_AMAX;
  assign w_lo   = w_sum < C_AMIN;
  assign w_accn = w_hi ? C_AMAX[ACC_WIDTH-1:0] : w_lo ? C_AMIN[ACC_WIDTH-1:0] : w_sum[ACC_WIDTH-1:0];

  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_data;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_m0 <= 1'b0;
      r_l0 <= 1'b0;
      r_a0 <= '0;
      r_b0 <= '0;
      r_v1 <= 1'b0;
      r_m1 <= 1'b0;
      r_l1 <= 1'b0;
      r_s1 <= 1'b0;
      r_z1 <= 1'b0;
      r_ka1 <= '0;
      r_kb1 <= '0;
      r_fa1 <= '0;
      r_fb1 <= '0;
      r_v2 <= 1'b0;
      r_m2 <= 1'b0;
      r_l2 <= 1'b0;
      r_s2 <= 1'b0;
      r_z2 <= 1'b0;
      r_i2 <= '0;
      r_f2 <= '0;
      r_v3 <= 1'b0;
      r_m3 <= 1'b0;
      r_l3 <= 1'b0;
      r_p3 <= '0;
      r_open <= 1'b0;
      r_acc <= '0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
    end else if (w_en) begin
      r_v0 <= in_valid;
      r_m0 <= mac_mode;
      r_l0 <= in_last;
      r_a0 <= in1;
      r_b0 <= in2;
      r_v1 <= r_v0;
      r_m1 <= r_m0;
      r_l1 <= r_l0;
      r_s1 <= r_a0[WIDTH-1] ^ r_b0[WIDTH-1];
      r_z1 <= (r_a0 == '0) | (r_b0 == '0);
      r_ka1 <= w_ka;
      r_kb1 <= w_kb;
      r_fa1 <= mant_frac(w_abs_a, w_ka);
      r_fb1 <= mant_frac(w_abs_b, w_kb);
      r_v2 <= r_v1;
      r_m2 <= r_m1;
      r_l2 <= r_l1;
      r_s2 <= r_s1;
      r_z2 <= r_z1;
      r_i2 <= w_int;
      r_f2 <= w_fsum[FRAC-1:0];
      r_v3 <= r_v2;
      r_m3 <= r_m2;
      r_l3 <= r_l2;
      r_p3 <= w_prod;
      r_out_valid <= r_v3 & (!r_m3 | r_l3);
      if (r_v3 & !r_m3)
        r_out_data <= w_pext;
      if (r_v3 & r_m3) begin
        r_acc <= w_accn;
        r_open <= !r_l3;
        if (r_l3)
          r_out_data <= w_accn;
      end
    end
  end

`ifdef LOGMAC_SAT_FLAG_EN
  logic r_sat;
  assign sat_flag = r_sat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sat <= 1'b0;
    else if (w_en & ((r_v2 & w_psat) | (r_v3 & r_m3 & (w_hi | w_lo))))
      r_sat <= 1'b1;
  end
`endif
endmodule
